// File: rtl/param_data_memory.sv
// param_data_memory: one read/write port (A), one read-only port (B), registered reads and a zero-fill sequencer
module param_data_memory #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_write_data,
  input  logic              a_memwrite,
  input  logic              a_memread,
  output logic [DATA_W-1:0] a_read_data,
  output logic              a_rvalid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_memread,
  output logic [DATA_W-1:0] b_read_data,
  output logic              b_rvalid,
  input  logic              clear,
  output logic              busy,
  output logic              addr_err
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(DEPTH);
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state;
  logic [IW-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic a_ok, b_ok, a_rd, a_wr, b_rd, we;
  logic [IW-1:0] wa, a_idx, b_idx;
  logic [DATA_W-1:0] wd;
  assign busy = state == CLEAR;
  always_comb begin
    a_ok  = {1'b0, a_addr} < LIM;
    b_ok  = {1'b0, b_addr} < LIM;
    a_idx = a_addr[IW-1:0];
    b_idx = b_addr[IW-1:0];
    a_rd  = !busy && a_memread;
    a_wr  = !busy && a_memwrite;
    b_rd  = !busy && b_memread;
    we    = !reset && (busy || (a_wr && a_ok));
    wa    = busy ? cnt : a_idx;
    wd    = busy ? '0 : a_write_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else if (busy) begin
      state <= (cnt == LAST) ? IDLE : CLEAR;
      cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end else if (clear) begin
      state <= CLEAR;
      cnt   <= '0;
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      a_read_data <= '0;
      b_read_data <= '0;
      a_rvalid    <= 1'b0;
      b_rvalid    <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      a_rvalid <= a_rd;
      b_rvalid <= b_rd;
      addr_err <= ((a_rd || a_wr) && !a_ok) || (b_rd && !b_ok);
      if (a_rd) a_read_data <= a_ok ? mem[a_idx] : '0;
      if (b_rd) b_read_data <= b_ok ? mem[b_idx] : '0;
    end
  end
endmodule

// File: doc/param_data_memory.md
PARAM_DATA_MEMORY -- requirements
Module: param_data_memory

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the word width in bits.
REQ-002 Parameter ADDR_W, default 16, SHALL set the address port width.
REQ-003 Parameter DEPTH, default 256, SHALL set the number of words, with DEPTH <= 2^ADDR_W and DEPTH >= 2.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 a_addr  input  ADDR_W  SHALL be the port A word address.
REQ-007 a_write_data  input  DATA_W  SHALL be the port A write data.
REQ-008 a_memwrite  input  1  SHALL request a port A write.
REQ-009 a_memread  input  1  SHALL request a port A read.
REQ-010 a_read_data  output  DATA_W  SHALL be the registered port A read data.
REQ-011 a_rvalid  output  1  SHALL flag a_read_data as updated this cycle.
REQ-012 b_addr  input  ADDR_W  SHALL be the port B word address (read-only port).
REQ-013 b_memread  input  1  SHALL request a port B read.
REQ-014 b_read_data  output  DATA_W  SHALL be the registered port B read data.
REQ-015 b_rvalid  output  1  SHALL flag b_read_data as updated this cycle.
REQ-016 clear  input  1  SHALL request a zero-fill of the whole array.
REQ-017 busy  output  1  SHALL be high while a zero-fill is in progress.
REQ-018 addr_err  output  1  SHALL pulse for one cycle after an accepted access to an address >= DEPTH.

Function
REQ-019 The control FSM SHALL have two states: CLEAR and IDLE.
REQ-020 In CLEAR, a counter SHALL write zero to word k in the k-th cycle, k = 0..DEPTH-1, then move to IDLE; busy SHALL be 1 exactly while in CLEAR.
REQ-021 In IDLE, clear=1 SHALL move the FSM to CLEAR on the next edge with the counter at 0; clear while in CLEAR SHALL be ignored (no restart).
REQ-022 While busy=1, a_memwrite, a_memread and b_memread SHALL be ignored: no array write, read data unchanged, rvalid 0, addr_err 0.
REQ-023 In IDLE, a_memwrite=1 with a_addr < DEPTH SHALL store a_write_data at a_addr on that edge.
REQ-024 Read latency SHALL be one cycle: an accepted memread in cycle n loads read_data and sets rvalid=1 in cycle n+1; rvalid SHALL be 0 in cycles with no accepted read.
REQ-025 read_data SHALL hold its last value when no read is accepted.
REQ-026 A read and a write to the same address in the same cycle (port A to itself, or port B against port A) SHALL return the pre-write (old) data.
REQ-027 Ports A and B SHALL operate independently and concurrently, including reads of the same address.
REQ-028 An accepted write with address >= DEPTH SHALL be dropped; an accepted read with address >= DEPTH SHALL return 0 with rvalid=1.
REQ-029 addr_err SHALL be 1 in cycle n+1 if any accepted access in cycle n on either port was out of range, else 0.

Reset
REQ-030 reset=1 SHALL on that edge force: FSM to CLEAR, counter 0, a_read_data=0, b_read_data=0, a_rvalid=0, b_rvalid=0, addr_err=0; busy SHALL read 1 from the following cycle.
REQ-031 Reset held for multiple cycles SHALL keep the counter at 0; the zero-fill SHALL start on the first edge with reset=0 and finish DEPTH cycles later.
REQ-032 Reset asserted mid-fill SHALL restart the fill from word 0.
REQ-033 Array contents SHALL only be zeroed by the fill sequence, never combinationally by reset.

Verification
REQ-034 Release reset, DEPTH=256 -> busy=1 for exactly 256 cycles, then 0; reads of words 0, 128, 255 return 0x00 with rvalid one cycle later.
REQ-035 IDLE: write 0xA5 to address 3, then read address 3 on port A -> a_read_data=0xA5, a_rvalid=1 in the cycle after the read; b_rvalid=0.
REQ-036 Same cycle: port A writes 0x3C to address 7 (old value 0x11), port B reads address 7 -> b_read_data=0x11; next port B read -> 0x3C.
REQ-037 Port A write 0xFF to address 300 and port B read of address 256 -> addr_err=1 for one cycle, b_read_data=0x00, b_rvalid=1, no word modified.
REQ-038 Write 0x55 to address 10, pulse clear, issue reads during busy -> no rvalid during busy; after busy falls, address 10 reads 0x00.
REQ-039 Assert reset at fill cycle 100 -> busy stays 1 and the fill completes 256 cycles after reset release.
